mem_port_arbiter: RTL and testbench

- Shares one unified memory port between instruction fetch (IF) and data memory (DM) requesters in the MIPS core.
- Arbitrates requests and registers the winner's address, write data and write-enable.
- Drives the select of the downstream address/data 2:1 mux (0 = IF, 1 = DM).
- Returns read data to the owning requester; aborts a transaction if the memory never acknowledges.

---
 rtl/mem_port_arbiter_if.sv | 52 +++++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester, memory and mux-select signals of the unified memory port
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_rvalid;
    logic [DW-1:0] dm_rdata;

    logic          err;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    logic          mux_sel;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        output err,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata,
        output mux_sel
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  err,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata,
        input  mux_sel
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/DM arbiter for one shared memory port with DM-streak limit and ack timeout
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MAX_STREAK = 3,
    parameter int TIMEOUT    = 15
) (
    input logic                clk,
    input logic                rst_n,
    mem_port_arbiter_if.slave  bus
);
    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]    state;
    logic [SW-1:0] streak;
    logic [TW-1:0] tcnt;
    logic          owner_dm;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          if_rvalid_q;
    logic          dm_rvalid_q;
    logic          err_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] dm_rdata_q;

    logic grant_if;
    logic grant_dm;
    logic ack_done;
    logic timeout_done;

    // DM normally has priority, but yields to a waiting IF once it has won MAX_STREAK times in a row
    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (state == S_IDLE) begin
            if (bus.dm_req && (streak < SW'(MAX_STREAK))) begin
                grant_dm = 1'b1;
            end else if (bus.if_req) begin
                grant_if = 1'b1;
            end else if (bus.dm_req) begin
                grant_dm = 1'b1;
            end
        end
    end

    // an ack on the last allowed cycle still counts as a normal completion
    assign ack_done     = (state == S_BUSY) && bus.mem_ack;
    assign timeout_done = (state == S_BUSY) && !bus.mem_ack && (tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            tcnt        <= '0;
            owner_dm    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            err_q       <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            err_q       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_if || grant_dm) begin
                        state       <= S_BUSY;
                        tcnt        <= '0;
                        owner_dm    <= grant_dm;
                        mem_addr_q  <= grant_dm ? bus.dm_addr : bus.if_addr;
                        mem_we_q    <= grant_dm && bus.dm_we;
                        mem_wdata_q <= grant_dm ? bus.dm_wdata : '0;
                    end
                end
                S_BUSY: begin
                    if (ack_done || timeout_done) begin
                        state <= S_IDLE;
                        err_q <= timeout_done;
                        if (owner_dm) begin
                            dm_rvalid_q <= 1'b1;
                            dm_rdata_q  <= ack_done ? bus.mem_rdata : '0;
                        end else begin
                            if_rvalid_q <= 1'b1;
                            if_rdata_q  <= ack_done ? bus.mem_rdata : '0;
                        end
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // streak counts back-to-back DM wins taken while IF was left waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak <= '0;
        end else if (grant_if) begin
            streak <= '0;
        end else if (grant_dm) begin
            if (!bus.if_req) begin
                streak <= '0;
            end else if (streak != SW'(MAX_STREAK)) begin
                streak <= streak + SW'(1);
            end
        end
    end

    assign bus.if_gnt    = grant_if;
    assign bus.dm_gnt    = grant_dm;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.dm_rvalid = dm_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.err       = err_q;
    assign bus.mem_req   = (state == S_BUSY);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mux_sel   = owner_dm;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int MAX_STREAK = 3;
    localparam int TIMEOUT    = 15;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .MAX_STREAK(MAX_STREAK), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ifr;
        logic [31:0] ifa;
        logic        dmr;
        logic        dmw;
        logic [31:0] dma;
        logic [31:0] dmd;
        int          lat;
        logic [31:0] rd;
        logic        exp_dm;
        logic        exp_err;
        int          exp_busy;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          busy;
        bit          done;
        logic [31:0] ea;
        logic [31:0] ed;
        logic        ew;
        step();
        bus.if_req   = v.ifr;
        bus.if_addr  = v.ifa;
        bus.dm_req   = v.dmr;
        bus.dm_we    = v.dmw;
        bus.dm_addr  = v.dma;
        bus.dm_wdata = v.dmd;
        bus.mem_ack  = 1'b0;
        #1;
        chk($sformatf("vec%0d if_gnt", idx), 64'(bus.if_gnt), 64'(!v.exp_dm));
        chk($sformatf("vec%0d dm_gnt", idx), 64'(bus.dm_gnt), 64'(v.exp_dm));
        ea = v.exp_dm ? v.dma : v.ifa;
        ew = v.exp_dm & v.dmw;
        ed = v.exp_dm ? v.dmd : 32'h0;
        busy = 0;
        done = 1'b0;
        for (int n = 1; n <= 40 && !done; n++) begin
            step();
            bus.if_req    = 1'b0;
            bus.dm_req    = 1'b0;
            bus.mem_ack   = (n == v.lat);
            bus.mem_rdata = v.rd;
            #1;
            if (bus.mem_req) begin
                busy++;
                if (n == 1) begin
                    chk($sformatf("vec%0d mem_addr", idx), 64'(bus.mem_addr), 64'(ea));
                    chk($sformatf("vec%0d mem_we", idx), 64'(bus.mem_we), 64'(ew));
                    chk($sformatf("vec%0d mem_wdata", idx), 64'(bus.mem_wdata), 64'(ed));
                    chk($sformatf("vec%0d mux_sel", idx), 64'(bus.mux_sel), 64'(v.exp_dm));
                end
            end else begin
                done = 1'b1;
                chk($sformatf("vec%0d if_rvalid", idx), 64'(bus.if_rvalid), 64'(!v.exp_dm));
                chk($sformatf("vec%0d dm_rvalid", idx), 64'(bus.dm_rvalid), 64'(v.exp_dm));
                chk($sformatf("vec%0d err", idx), 64'(bus.err), 64'(v.exp_err));
                if (v.exp_dm) chk($sformatf("vec%0d dm_rdata", idx), 64'(bus.dm_rdata), 64'(v.exp_rd));
                else          chk($sformatf("vec%0d if_rdata", idx), 64'(bus.if_rdata), 64'(v.exp_rd));
            end
        end
        bus.mem_ack = 1'b0;
        chk($sformatf("vec%0d completed", idx), 64'(done), 64'(1));
        chk($sformatf("vec%0d busy cycles", idx), 64'(busy), 64'(v.exp_busy));
    endtask

    int          order[$];
    int          exp_order[8];
    int          busy_until, ack_at, done_at, run;
    bit          busy, done_dm, done_err, ifh, dmh, dm_w, if_w;
    logic [31:0] txn_data, done_data, last_if, last_dm;
    logic [31:0] e_addr, e_wdata;
    logic        e_we, e_dm;
    int          lat, nb;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;

        vecs[0] = '{1'b1, 32'h0040_0000, 1'b0, 1'b0, 32'h0, 32'h0, 3, 32'h2008_0005, 1'b0, 1'b0, 3, 32'h2008_0005};
        vecs[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 1, 32'h1234_5678, 1'b1, 1'b0, 1, 32'h1234_5678};
        vecs[2] = '{1'b1, 32'h0040_0004, 1'b1, 1'b0, 32'h1001_0008, 32'h0, 2, 32'hCAFE_F00D, 1'b1, 1'b0, 2, 32'hCAFE_F00D};
        vecs[3] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h1001_000C, 32'h0, 99, 32'h5555_5555, 1'b1, 1'b1, 15, 32'h0};
        vecs[4] = '{1'b1, 32'h0040_0008, 1'b0, 1'b0, 32'h0, 32'h0, 15, 32'hA5A5_A5A5, 1'b0, 1'b0, 15, 32'hA5A5_A5A5};
        vecs[5] = '{1'b1, 32'h0040_000C, 1'b1, 1'b1, 32'h1001_0010, 32'h0BAD_C0DE, 1, 32'h1111_2222, 1'b1, 1'b0, 1, 32'h1111_2222};
        vecs[6] = '{1'b1, 32'h0040_0010, 1'b0, 1'b0, 32'h0, 32'h0, 4, 32'h3333_4444, 1'b0, 1'b0, 4, 32'h3333_4444};
        exp_order = '{1, 1, 1, 0, 1, 1, 1, 0};

        // reset state
        repeat (3) step();
        chk("rst if_gnt", 64'(bus.if_gnt), 64'(0));
        chk("rst dm_gnt", 64'(bus.dm_gnt), 64'(0));
        chk("rst if_rvalid", 64'(bus.if_rvalid), 64'(0));
        chk("rst dm_rvalid", 64'(bus.dm_rvalid), 64'(0));
        chk("rst err", 64'(bus.err), 64'(0));
        chk("rst mem_req", 64'(bus.mem_req), 64'(0));
        chk("rst mem_we", 64'(bus.mem_we), 64'(0));
        chk("rst mem_addr", 64'(bus.mem_addr), 64'(0));
        chk("rst mem_wdata", 64'(bus.mem_wdata), 64'(0));
        chk("rst mux_sel", 64'(bus.mux_sel), 64'(0));
        chk("rst if_rdata", 64'(bus.if_rdata), 64'(0));
        chk("rst dm_rdata", 64'(bus.dm_rdata), 64'(0));
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // starvation: both requesters held, single-cycle acks
        for (int n = 0; n < 60 && order.size() < 8; n++) begin
            step();
            bus.if_req = 1'b1; bus.if_addr = 32'h0040_0100;
            bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h1001_0100;
            bus.mem_ack = bus.mem_req;
            #1;
            if (bus.if_gnt) order.push_back(0);
            if (bus.dm_gnt) order.push_back(1);
        end
        chk("starve grant count", 64'(order.size()), 64'(8));
        for (int i = 0; i < 8; i++)
            if (i < order.size()) chk($sformatf("starve grant %0d", i), 64'(order[i]), 64'(exp_order[i]));
        for (int n = 0; n < 3; n++) begin
            step();
            bus.if_req = 1'b0; bus.dm_req = 1'b0;
            bus.mem_ack = bus.mem_req;
        end
        bus.mem_ack = 1'b0;

        // reset in the middle of a DM read
        step();
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h1001_0020;
        #1;
        chk("rstmid dm_gnt", 64'(bus.dm_gnt), 64'(1));
        step();
        bus.dm_req = 1'b0;
        #1;
        chk("rstmid busy mem_req", 64'(bus.mem_req), 64'(1));
        chk("rstmid busy mux_sel", 64'(bus.mux_sel), 64'(1));
        step();
        rst_n = 1'b0;
        #1;
        chk("rstmid mem_req", 64'(bus.mem_req), 64'(0));
        chk("rstmid mux_sel", 64'(bus.mux_sel), 64'(0));
        chk("rstmid dm_rdata", 64'(bus.dm_rdata), 64'(0));
        for (int n = 0; n < 2; n++) begin
            step();
            chk("rstmid dm_rvalid", 64'(bus.dm_rvalid), 64'(0));
            chk("rstmid err", 64'(bus.err), 64'(0));
        end
        step();
        rst_n = 1'b1;
        bus.if_req = 1'b1; bus.if_addr = 32'h0040_0200;
        #1;
        chk("rstmid if_gnt after release", 64'(bus.if_gnt), 64'(1));
        step();
        bus.if_req = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h7777_8888;
        #1;
        chk("rstmid if mem_addr", 64'(bus.mem_addr), 64'(32'h0040_0200));
        chk("rstmid if mux_sel", 64'(bus.mux_sel), 64'(0));
        step();
        bus.mem_ack = 1'b0;
        #1;
        chk("rstmid if_rvalid", 64'(bus.if_rvalid), 64'(1));
        chk("rstmid if_rdata", 64'(bus.if_rdata), 64'(32'h7777_8888));
        chk("rstmid stray dm_rvalid", 64'(bus.dm_rvalid), 64'(0));

        // randomized traffic against a transaction-level model
        step();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        busy_until = -1; ack_at = -1; done_at = -1; run = 0;
        last_if = '0; last_dm = '0; ifh = 1'b0; dmh = 1'b0;
        e_addr = '0; e_wdata = '0; e_we = 1'b0; e_dm = 1'b0;
        done_dm = 1'b0; done_err = 1'b0; done_data = '0; txn_data = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            busy = (cyc <= busy_until);
            bus.mem_rdata = $urandom;
            if (busy && cyc == ack_at) begin
                bus.mem_ack = 1'b1;
                bus.mem_rdata = txn_data;
            end else begin
                bus.mem_ack = !busy && ($urandom_range(0, 7) == 0);
            end
            if (!ifh) begin
                if ($urandom_range(0, 2) == 0) begin ifh = 1'b1; bus.if_req = 1'b1; bus.if_addr = $urandom; end
                else bus.if_req = 1'b0;
            end else if ($urandom_range(0, 15) == 0) begin
                ifh = 1'b0; bus.if_req = 1'b0;
            end
            if (!dmh) begin
                if ($urandom_range(0, 2) == 0) begin
                    dmh = 1'b1; bus.dm_req = 1'b1; bus.dm_addr = $urandom;
                    bus.dm_we = 1'($urandom_range(0, 1)); bus.dm_wdata = $urandom;
                end else bus.dm_req = 1'b0;
            end else if ($urandom_range(0, 15) == 0) begin
                dmh = 1'b0; bus.dm_req = 1'b0;
            end
            #1;
            if (cyc == done_at) begin
                if (done_dm) last_dm = done_data; else last_if = done_data;
            end
            chk("rnd if_rvalid", 64'(bus.if_rvalid), 64'(cyc == done_at && !done_dm));
            chk("rnd dm_rvalid", 64'(bus.dm_rvalid), 64'(cyc == done_at && done_dm));
            chk("rnd err", 64'(bus.err), 64'(cyc == done_at && done_err));
            chk("rnd if_rdata", 64'(bus.if_rdata), 64'(last_if));
            chk("rnd dm_rdata", 64'(bus.dm_rdata), 64'(last_dm));
            chk("rnd mem_req", 64'(bus.mem_req), 64'(busy));
            if (busy) begin
                chk("rnd busy gnt", 64'({bus.if_gnt, bus.dm_gnt}), 64'(0));
                chk("rnd mem_addr", 64'(bus.mem_addr), 64'(e_addr));
                chk("rnd mem_we", 64'(bus.mem_we), 64'(e_we));
                chk("rnd mem_wdata", 64'(bus.mem_wdata), 64'(e_wdata));
                chk("rnd mux_sel", 64'(bus.mux_sel), 64'(e_dm));
            end else begin
                dm_w = bus.dm_req && (run < MAX_STREAK || !bus.if_req);
                if_w = bus.if_req && !dm_w;
                chk("rnd if_gnt", 64'(bus.if_gnt), 64'(if_w));
                chk("rnd dm_gnt", 64'(bus.dm_gnt), 64'(dm_w));
                if (dm_w || if_w) begin
                    e_dm    = dm_w;
                    e_addr  = dm_w ? bus.dm_addr : bus.if_addr;
                    e_we    = dm_w && bus.dm_we;
                    e_wdata = dm_w ? bus.dm_wdata : 32'h0;
                    run     = (dm_w && bus.if_req) ? run + 1 : 0;
                    lat      = $urandom_range(1, TIMEOUT + 3);
                    nb       = (lat <= TIMEOUT) ? lat : TIMEOUT;
                    txn_data = $urandom;
                    busy_until = cyc + nb;
                    ack_at     = (lat <= TIMEOUT) ? cyc + lat : -1;
                    done_at    = cyc + nb + 1;
                    done_dm    = dm_w;
                    done_err   = (lat > TIMEOUT);
                    done_data  = done_err ? 32'h0 : txn_data;
                    if (dm_w) dmh = 1'b0; else ifh = 1'b0;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
